// File: rtl/conv5_window_ctrl_if.sv
// Handshake and window-status bundle between the pixel source and conv5_window_ctrl.
// OCW/ORW must match the output-map index widths of the attached controller.
interface conv5_window_ctrl_if #(
  parameter int OCW = 1,
  parameter int ORW = 1
);
  logic           Start;
  logic           Valid_IN;
  logic           Pixel_Ready;
  logic           Shift_EN;
  logic           Win_Valid;
  logic [OCW-1:0] Out_Col;
  logic [ORW-1:0] Out_Row;
  logic           Busy;
  logic           Frame_Done;

  modport master (
    output Start, Valid_IN,
    input  Pixel_Ready, Shift_EN, Win_Valid, Out_Col, Out_Row, Busy, Frame_Done
  );

  modport slave (
    input  Start, Valid_IN,
    output Pixel_Ready, Shift_EN, Win_Valid, Out_Col, Out_Row, Busy, Frame_Done
  );
endinterface

// File: rtl/conv5_window_ctrl.sv
// Raster-scan controller for a 5x5 line-buffer window: counts accepted pixels and
// flags each legal strided window together with its output-map coordinates.
module conv5_window_ctrl #(
  parameter int IMG_Width  = 28,
  parameter int IMG_Height = 28,
  parameter int Stride     = 1
) (
  input logic CLK,
  input logic CLR,
  conv5_window_ctrl_if.slave bus
);
  localparam int CW  = $clog2(IMG_Width);
  localparam int RW  = $clog2(IMG_Height);
  localparam int OW  = (IMG_Width - 5) / Stride + 1;
  localparam int OH  = (IMG_Height - 5) / Stride + 1;
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
  localparam int ORW = (OH > 1) ? $clog2(OH) : 1;
  localparam int PW  = (Stride > 1) ? $clog2(Stride) : 1;

  localparam logic [CW-1:0] ColLast = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] Col3    = CW'(3);
  localparam logic [CW-1:0] Col4    = CW'(4);
  localparam logic [RW-1:0] Row3    = RW'(3);
  localparam logic [RW-1:0] Row4    = RW'(4);
  localparam logic [PW-1:0] PhLast  = PW'(Stride - 1);

  if (IMG_Width < 5)  begin : g_badWidth  $error("IMG_Width must be >= 5");  end
  if (IMG_Height < 5) begin : g_badHeight $error("IMG_Height must be >= 5"); end
  if (Stride < 1 || Stride > 4) begin : g_badStride $error("Stride must be 1..4"); end

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PW-1:0]  colPh_q, colPh_d, rowPh_q, rowPh_d;
  logic [OCW-1:0] colIdx_q, colIdx_d, outCol_q, outCol_d;
  logic [ORW-1:0] rowIdx_q, rowIdx_d, outRow_q, outRow_d;
  logic           ready_q, ready_d, busy_q, busy_d;
  logic           winValid_q, winValid_d, frameDone_q, frameDone_d;
  logic           accept;

  assign accept = bus.Valid_IN & ready_q;

  // Phase counters track (c-4)%Stride and (r-4)%Stride; the Idx counters carry the
  // matching quotient, so no divider is needed to locate strided windows.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    colPh_d     = colPh_q;
    rowPh_d     = rowPh_q;
    colIdx_d    = colIdx_q;
    rowIdx_d    = rowIdx_q;
    outCol_d    = outCol_q;
    outRow_d    = outRow_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    winValid_d  = 1'b0;
    frameDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d  = FILL;
          col_d    = '0;
          row_d    = '0;
          colPh_d  = '0;
          rowPh_d  = '0;
          colIdx_d = '0;
          rowIdx_d = '0;
          ready_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      FILL, RUN: begin
        if (accept) begin
          winValid_d = (row_q >= Row4) && (col_q >= Col4) && (rowPh_q == '0) && (colPh_q == '0);
          if (winValid_d) begin
            outCol_d = colIdx_q;
            outRow_d = rowIdx_q;
          end
          if (row_q == RowLast && col_q == ColLast) begin
            state_d     = DONE;
            ready_d     = 1'b0;
            frameDone_d = 1'b1;
          end else begin
            if (state_q == FILL && row_q == Row4 && col_q == Col3) begin
              state_d = RUN;
            end
            if (col_q == ColLast) begin
              col_d    = '0;
              colPh_d  = '0;
              colIdx_d = '0;
              row_d    = row_q + RW'(1);
              if (row_q == Row3) begin
                rowPh_d  = '0;
                rowIdx_d = '0;
              end else if (row_q >= Row4) begin
                if (rowPh_q == PhLast) begin
                  rowPh_d  = '0;
                  rowIdx_d = rowIdx_q + ORW'(1);
                end else begin
                  rowPh_d = rowPh_q + PW'(1);
                end
              end
            end else begin
              col_d = col_q + CW'(1);
              if (col_q == Col3) begin
                colPh_d  = '0;
                colIdx_d = '0;
              end else if (col_q >= Col4) begin
                if (colPh_q == PhLast) begin
                  colPh_d  = '0;
                  colIdx_d = colIdx_q + OCW'(1);
                end else begin
                  colPh_d = colPh_q + PW'(1);
                end
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      colPh_q     <= '0;
      rowPh_q     <= '0;
      colIdx_q    <= '0;
      rowIdx_q    <= '0;
      outCol_q    <= '0;
      outRow_q    <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      colPh_q     <= colPh_d;
      rowPh_q     <= rowPh_d;
      colIdx_q    <= colIdx_d;
      rowIdx_q    <= rowIdx_d;
      outCol_q    <= outCol_d;
      outRow_q    <= outRow_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      winValid_q  <= winValid_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign bus.Pixel_Ready = ready_q;
  assign bus.Shift_EN    = accept;
  assign bus.Win_Valid   = winValid_q;
  assign bus.Out_Col     = outCol_q;
  assign bus.Out_Row     = outRow_q;
  assign bus.Busy        = busy_q;
  assign bus.Frame_Done  = frameDone_q;
endmodule

// File: tb/tb_conv5_window_ctrl.sv
// Randomized bench for conv5_window_ctrl: a 7x7/stride-1 and a 9x9/stride-2 instance
// are driven in turn and compared every cycle against a pixel-index reference model.
module tb_conv5_window_ctrl;
  localparam int AW = 7, AH = 7, AS = 1;
  localparam int BW = 9, BH = 9, BS = 2;
  localparam int A_OW = (AW - 5) / AS + 1, A_OH = (AH - 5) / AS + 1;
  localparam int B_OW = (BW - 5) / BS + 1, B_OH = (BH - 5) / BS + 1;
  localparam int A_OCW = (A_OW > 1) ? $clog2(A_OW) : 1;
  localparam int A_ORW = (A_OH > 1) ? $clog2(A_OH) : 1;
  localparam int B_OCW = (B_OW > 1) ? $clog2(B_OW) : 1;
  localparam int B_ORW = (B_OH > 1) ? $clog2(B_OH) : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr = 1'b1, sel = 1'b0, vinT = 1'b0, startT = 1'b0;

  conv5_window_ctrl_if #(.OCW(A_OCW), .ORW(A_ORW)) busA ();
  conv5_window_ctrl_if #(.OCW(B_OCW), .ORW(B_ORW)) busB ();

  assign busA.Start    = startT & ~sel;
  assign busA.Valid_IN = vinT & ~sel;
  assign busB.Start    = startT & sel;
  assign busB.Valid_IN = vinT & sel;

  conv5_window_ctrl #(.IMG_Width(AW), .IMG_Height(AH), .Stride(AS)) dutA (
    .CLK(clk), .CLR(clr), .bus(busA));
  conv5_window_ctrl #(.IMG_Width(BW), .IMG_Height(BH), .Stride(BS)) dutB (
    .CLK(clk), .CLR(clr), .bus(busB));

  logic        obsReady, obsShift, obsWin, obsBusy, obsFd;
  logic [31:0] obsCol, obsRow;

  always_comb begin
    obsReady = sel ? busB.Pixel_Ready : busA.Pixel_Ready;
    obsShift = sel ? busB.Shift_EN    : busA.Shift_EN;
    obsWin   = sel ? busB.Win_Valid   : busA.Win_Valid;
    obsBusy  = sel ? busB.Busy        : busA.Busy;
    obsFd    = sel ? busB.Frame_Done  : busA.Frame_Done;
    obsCol   = sel ? 32'(busB.Out_Col) : 32'(busA.Out_Col);
    obsRow   = sel ? 32'(busB.Out_Row) : 32'(busA.Out_Row);
  end

  // Reference model: mMode 0 = idle, 1 = accepting pixels, 2 = end-of-frame cycle
  int mMode = 0, mPix = 0, mOutC = 0, mOutR = 0;
  bit mWin = 0, mFd = 0;
  int curW = AW, curH = AH, curS = AS;

  int checks = 0, passes = 0, fails = 0;
  int winSeen, fdSeen, lastOutC, lastOutR;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic vin);
    check("Pixel_Ready", 32'(obsReady), 32'(mMode == 1));
    check("Shift_EN", 32'(obsShift), 32'(vin && mMode == 1));
    check("Busy", 32'(obsBusy), 32'(mMode != 0));
    check("Win_Valid", 32'(obsWin), 32'(mWin));
    check("Frame_Done", 32'(obsFd), 32'(mFd));
    check("Out_Col", obsCol, 32'(mOutC));
    check("Out_Row", obsRow, 32'(mOutR));
    if (obsWin === 1'b1) winSeen++;
    if (obsFd === 1'b1) begin
      fdSeen++;
      lastOutC = int'(obsCol);
      lastOutR = int'(obsRow);
    end
  endtask

  task automatic modelUpdate(input logic vin, input logic start, input logic c);
    int r, cc;
    if (c) begin
      mMode = 0; mPix = 0; mWin = 0; mFd = 0; mOutC = 0; mOutR = 0;
    end else begin
      mWin = 0;
      mFd  = 0;
      case (mMode)
        0: if (start) begin mMode = 1; mPix = 0; end
        1: if (vin) begin
          r  = mPix / curW;
          cc = mPix % curW;
          if (r >= 4 && cc >= 4 && (r - 4) % curS == 0 && (cc - 4) % curS == 0) begin
            mWin  = 1;
            mOutC = (cc - 4) / curS;
            mOutR = (r - 4) / curS;
          end
          mPix++;
          if (mPix == curW * curH) begin
            mMode = 2;
            mFd   = 1;
          end
        end
        default: mMode = 0;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic vin, input logic start, input logic c);
    vinT   = vin;
    startT = start;
    clr    = c;
    #1;
    checkOutput(vin);
    @(posedge clk);
    modelUpdate(vin, start, c);
    @(negedge clk);
  endtask

  // Switching instances resets both so the model's held outputs are valid again
  task automatic selectDut(input logic s);
    sel    = s;
    curW   = s ? BW : AW;
    curH   = s ? BH : AH;
    curS   = s ? BS : AS;
    vinT   = 1'b0;
    startT = 1'b0;
    clr    = 1'b1;
    @(posedge clk);
    modelUpdate(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic runFrame(input int vmode, input int abortAt, input int expWins);
    int  i;
    logic vin, st, c;
    winSeen = 0;
    fdSeen  = 0;
    lastOutC = -1;
    lastOutR = -1;
    applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    i = 0;
    while (mMode != 0 && i < 4000) begin
      case (vmode)
        0:       vin = 1'b1;
        1:       vin = (i % 2 == 0);
        default: vin = ($urandom_range(0, 2) != 0);
      endcase
      st = ($urandom_range(0, 4) == 0);
      c  = (abortAt >= 0 && mMode == 1 && mPix == abortAt);
      applyStimulus(vin, st, c);
      i++;
    end
    if (i >= 4000) check("frameTimeout", 32'(obsBusy), 32'd0);
    for (int k = 0; k < 4; k++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    if (abortAt >= 0) begin
      check("abortNoDone", 32'(fdSeen), 32'd0);
    end else begin
      check("winCount", 32'(winSeen), 32'(expWins));
      check("doneCount", 32'(fdSeen), 32'd1);
      check("lastOutCol", 32'(lastOutC), 32'(2));
      check("lastOutRow", 32'(lastOutR), 32'(2));
    end
  endtask

  initial begin
    selectDut(1'b0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] 7x7 stride 1, continuous pixels");
    runFrame(0, -1, 9);
    $display("[TB] 7x7 stride 1, alternating pixel gaps");
    runFrame(1, -1, 9);
    $display("[TB] 7x7 stride 1, reset at pixel 20 then fresh frame");
    runFrame(0, 20, 0);
    runFrame(0, -1, 9);
    $display("[TB] 7x7 stride 1, random gaps");
    runFrame(2, -1, 9);

    selectDut(1'b1);
    $display("[TB] 9x9 stride 2, continuous pixels");
    runFrame(0, -1, 9);
    $display("[TB] 9x9 stride 2, random gaps");
    runFrame(2, -1, 9);
    runFrame(2, 37, 0);
    runFrame(1, -1, 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/conv5_window_ctrl.md
CONV5_WINDOW_CTRL -- requirements
Module: conv5_window_ctrl

Interface
REQ-001 Parameter IMG_Width, default 28, frame width in pixels; the block SHALL require IMG_Width >= 5.
REQ-002 Parameter IMG_Height, default 28, frame height in pixels; the block SHALL require IMG_Height >= 5.
REQ-003 Parameter Stride, default 1, window step in both axes; the block SHALL require 1 <= Stride <= 4.
REQ-004 Derived widths SHALL be: CW = $clog2(IMG_Width), RW = $clog2(IMG_Height), OW = (IMG_Width-5)/Stride+1, OH = (IMG_Height-5)/Stride+1.
REQ-005 Port CLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 Port CLR, input, 1, reset, synchronous and active-high.
REQ-007 Port Start, input, 1, frame start request.
REQ-008 Port Valid_IN, input, 1, upstream pixel strobe.
REQ-009 Port Pixel_Ready, output, 1, block accepts pixels this cycle.
REQ-010 Port Shift_EN, output, 1, shift enable to the 5x5 line-buffer window (its WE).
REQ-011 Port Win_Valid, output, 1, line-buffer window holds a legal strided 5x5 window.
REQ-012 Port Out_Col, output, $clog2(OW) (min 1), output-map column of the current window.
REQ-013 Port Out_Row, output, $clog2(OH) (min 1), output-map row of the current window.
REQ-014 Port Busy, output, 1, frame in progress.
REQ-015 Port Frame_Done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-016 FSM states SHALL be IDLE, FILL, RUN and DONE.
REQ-017 IDLE -> FILL SHALL occur on Start=1; Valid_IN in that same cycle SHALL NOT be accepted.
REQ-018 FILL -> RUN SHALL occur on acceptance of pixel index 4*IMG_Width+3, i.e. row 4, col 3.
REQ-019 FILL or RUN -> DONE SHALL occur on acceptance of pixel (IMG_Height-1, IMG_Width-1).
REQ-020 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-021 Pixel_Ready SHALL be 1 in FILL and RUN only; Busy SHALL be 1 in FILL, RUN and DONE.
REQ-022 A pixel is accepted when Valid_IN=1 and Pixel_Ready=1; Shift_EN SHALL equal Valid_IN & Pixel_Ready combinationally.
REQ-023 Col counter (CW bits) SHALL increment per accepted pixel, wrap IMG_Width-1 -> 0, and increment Row counter (RW bits) on wrap.
REQ-024 Col and Row SHALL clear to 0 on entering FILL.
REQ-025 Win_Valid SHALL be registered: 1 in the cycle after accepting pixel (r,c) iff r>=4, c>=4, (r-4)%Stride==0 and (c-4)%Stride==0; otherwise 0.
REQ-026 Win_Valid SHALL therefore align with the window update made by the same Shift_EN edge, and SHALL never flag windows spanning a row wrap (c<4).
REQ-027 Out_Col and Out_Row SHALL be registered with Win_Valid, equal (c-4)/Stride and (r-4)/Stride for the flagged window, and hold their value otherwise.
REQ-028 Stride modulo tests SHALL use phase counters that reset at col/row 4 and wrap at Stride-1; no divider SHALL be used.
REQ-029 Frame_Done SHALL be 1 exactly in the DONE cycle; the final Win_Valid, when present, SHALL coincide with it.
REQ-030 Gaps in Valid_IN SHALL stall counters and produce Win_Valid=0 for each gap cycle.
REQ-031 Start while Busy=1, including in DONE, SHALL be ignored.
REQ-032 Valid_IN in IDLE or DONE SHALL be ignored, with Shift_EN=0.

Reset
REQ-033 CLR=1 SHALL, at the next edge, force IDLE and clear all counters, phases, Win_Valid, Out_Col, Out_Row and Frame_Done to 0, overriding Start and Valid_IN.
REQ-034 In IDLE after reset, Pixel_Ready, Shift_EN and Busy SHALL be 0.
REQ-035 CLR mid-frame SHALL abort the frame without a Frame_Done pulse; the next Start SHALL restart from pixel (0,0).

Verification
REQ-036 W=H=7, S=1, continuous Valid_IN after Start -> FILL->RUN after pixel 31; first Win_Valid the cycle after pixel 32 with Out=(0,0); 9 windows total; last window Out=(2,2) coincides with Frame_Done.
REQ-037 W=H=9, S=2 -> 9 windows at cols/rows 4, 6, 8; Out_Col sequence 0,1,2 per output row; Win_Valid=0 at odd cols and rows.
REQ-038 W=H=7, S=1, Valid_IN toggling 1,0 -> same 9 windows in the same order; Shift_EN=0 and Win_Valid=0 in every gap cycle.
REQ-039 CLR asserted at pixel 20 -> IDLE next cycle, all outputs 0, no Frame_Done; a fresh Start yields the full REQ-036 sequence.
REQ-040 Start pulsed during RUN and during DONE, and Valid_IN asserted in IDLE -> no restart and no counter change; Frame_Done is a single one-cycle pulse.
